fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000; PC value loaded on reset.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 StallF  input  1  1 = hold the current fetched instruction and PC.
REQ-005 PCSrcE  input  1  1 = redirect fetch to PCTargetE (taken branch or jump).
REQ-006 PCTargetE  input  32  redirect target address.
REQ-007 imem_req  output  1  instruction memory request valid.
REQ-008 imem_addr  output  32  request address, always equal to PCF.
REQ-009 imem_ack  input  1  memory accepts the request; imem_rdata valid in the same cycle.
REQ-010 imem_rdata  input  32  instruction word.
REQ-011 InstrF  output  32  registered instruction toward the decode pipeline register.
REQ-012 PCF  output  32  registered PC of InstrF or of the outstanding request.
REQ-013 PCPlus4F  output  32  PCF + 4, registered.
REQ-014 ValidF  output  1  1 = InstrF/PCF/PCPlus4F hold a usable instruction.
REQ-015 FetchStall  output  1  1 while a memory request is outstanding; the hazard unit uses it to hold or bubble decode.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, HAVE and DROP.
REQ-017 IDLE SHALL last exactly one cycle after rst_n rises, then go to FETCH.
REQ-018 imem_req SHALL be 1 in FETCH and DROP and 0 in IDLE and HAVE.
REQ-019 imem_addr SHALL be PCF with bits [1:0] forced to 0, and SHALL stay stable while imem_req=1 and imem_ack=0.
REQ-020 A transfer SHALL occur when imem_req=1 and imem_ack=1 at a rising edge.
REQ-021 FETCH, ack, PCSrcE=0: InstrF<=imem_rdata; ValidF<=1; go to HAVE.
REQ-022 FETCH, ack, PCSrcE=1: discard imem_rdata; PCF<=PCTargetE; stay in FETCH; ValidF stays 0.
REQ-023 FETCH, no ack, PCSrcE=1: PendTarget<=PCTargetE; go to DROP; PCF unchanged.
REQ-024 DROP, PCSrcE=1: PendTarget<=PCTargetE; the latest redirect wins.
REQ-025 DROP, ack: discard imem_rdata; PCF<=PCSrcE ? PCTargetE : PendTarget; go to FETCH.
REQ-026 HAVE, PCSrcE=1: PCF<=PCTargetE; InstrF<=0; ValidF<=0; go to FETCH.
REQ-027 HAVE, PCSrcE=1 takes priority over StallF.
REQ-028 HAVE, PCSrcE=0, StallF=0: PCF<=PCPlus4F; ValidF<=0; go to FETCH.
REQ-029 HAVE, PCSrcE=0, StallF=1: all outputs and state hold.
REQ-030 StallF SHALL have no effect in FETCH or DROP.
REQ-031 PCPlus4F SHALL always equal PCF+4 modulo 2^32; 32'hFFFF_FFFC wraps to 0.
REQ-032 Whenever PCF is loaded from PCTargetE or PendTarget, bits [1:0] SHALL be forced to 0.
REQ-033 FetchStall SHALL equal 1 in IDLE, FETCH and DROP, and 0 in HAVE.
REQ-034 Peak throughput SHALL be one instruction per two cycles with zero-wait memory.

Reset
REQ-035 rst_n=0 SHALL immediately set state=IDLE, PCF=RESET_PC, PCPlus4F=RESET_PC+4, InstrF=0, ValidF=0, imem_req=0, PendTarget=0.
REQ-036 Reset asserted during an outstanding request SHALL abandon that request; no data from it SHALL reach InstrF.

Structure
REQ-037 Package fetch_pkg SHALL hold the FSM state enum, the default RESET_PC constant and the NOP/bubble encoding (32'h0).
REQ-038 No sub-module; the FSM and the PC datapath SHALL be in one module.

Verification
REQ-039 Reset with RESET_PC=32'h100, ack tied high: imem_addr is 100, 104, 108 on alternating cycles; ValidF pulses with the matching InstrF.
REQ-040 Ack delayed 3 cycles: imem_addr stays 32'h104 and FetchStall=1 throughout; InstrF updates only on the ack cycle.
REQ-041 In HAVE, hold StallF=1 for 4 cycles: InstrF, PCF and ValidF are unchanged; no imem_req is issued.
REQ-042 In FETCH with no ack, PCSrcE=1 to 32'h200: old rdata is dropped on ack; the next imem_addr is 32'h200; ValidF never shows the dropped word.
REQ-043 In HAVE, PCSrcE=1 to 32'h203 together with StallF=1: PCF=32'h200, ValidF=0, state is FETCH.
REQ-044 PCF=32'hFFFF_FFFC advances to 0 with PCPlus4F=4; rst_n pulsed low mid-request drops imem_req asynchronously and PCF returns to RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HAVE  = 2'd2,
        S_DROP  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding request at a time, with redirects
// that land while a request is in flight remembered and applied once it completes.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        ValidF,
    output logic        FetchStall
);

    fetch_state_t state;
    logic [31:0]  pend_target;

    assign imem_addr = align_pc(PCF);

    // A response that arrives after a redirect belongs to the old path and is
    // thrown away; the request is then reissued at the redirect target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            PCF         <= RESET_PC;
            PCPlus4F    <= RESET_PC + 32'd4;
            InstrF      <= NOP_INSTR;
            ValidF      <= 1'b0;
            imem_req    <= 1'b0;
            FetchStall  <= 1'b1;
            pend_target <= 32'h0000_0000;
        end else begin
            case (state)
                S_IDLE: begin
                    state      <= S_FETCH;
                    imem_req   <= 1'b1;
                    FetchStall <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        if (PCSrcE) begin
                            PCF      <= align_pc(PCTargetE);
                            PCPlus4F <= align_pc(PCTargetE) + 32'd4;
                        end else begin
                            InstrF     <= imem_rdata;
                            ValidF     <= 1'b1;
                            state      <= S_HAVE;
                            imem_req   <= 1'b0;
                            FetchStall <= 1'b0;
                        end
                    end else if (PCSrcE) begin
                        pend_target <= PCTargetE;
                        state       <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (PCSrcE) begin
                        pend_target <= PCTargetE;
                    end
                    if (imem_ack) begin
                        state <= S_FETCH;
                        if (PCSrcE) begin
                            PCF      <= align_pc(PCTargetE);
                            PCPlus4F <= align_pc(PCTargetE) + 32'd4;
                        end else begin
                            PCF      <= align_pc(pend_target);
                            PCPlus4F <= align_pc(pend_target) + 32'd4;
                        end
                    end
                end
                S_HAVE: begin
                    // A redirect overrides a decode stall: the held instruction is on the wrong path.
                    if (PCSrcE) begin
                        PCF        <= align_pc(PCTargetE);
                        PCPlus4F   <= align_pc(PCTargetE) + 32'd4;
                        InstrF     <= NOP_INSTR;
                        ValidF     <= 1'b0;
                        state      <= S_FETCH;
                        imem_req   <= 1'b1;
                        FetchStall <= 1'b1;
                    end else if (!StallF) begin
                        PCF        <= PCPlus4F;
                        PCPlus4F   <= PCPlus4F + 32'd4;
                        ValidF     <= 1'b0;
                        state      <= S_FETCH;
                        imem_req   <= 1'b1;
                        FetchStall <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a flag-based reference model of the fetch protocol.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        StallF = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        ValidF;
    logic        FetchStall;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: "started" after the post-reset idle cycle, "waiting" while a
    // request is in flight, "dropping" when that request's data must be discarded.
    bit          m_started, m_waiting, m_dropping, m_valid;
    logic [31:0] m_pc, m_instr, m_pend;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .StallF(StallF), .PCSrcE(PCSrcE),
        .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .InstrF(InstrF),
        .PCF(PCF), .PCPlus4F(PCPlus4F), .ValidF(ValidF), .FetchStall(FetchStall)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_started = 0; m_waiting = 0; m_dropping = 0; m_valid = 0;
        m_pc = RPC; m_instr = 32'h0; m_pend = 32'h0;
    endtask

    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    // Drive one cycle of inputs from a negedge, advance the model across the
    // posedge, and return at the following negedge ready for sampling.
    task automatic applyStimulus(input logic stall, input logic src, input logic [31:0] tgt,
                                 input logic ack, input logic [31:0] rdata);
        StallF = stall; PCSrcE = src; PCTargetE = tgt; imem_ack = ack; imem_rdata = rdata;
        @(posedge clk);
        if (!m_started) begin
            m_started = 1; m_waiting = 1;
        end else if (m_waiting) begin
            if (m_dropping) begin
                if (ack) begin
                    m_pc = word_addr(src ? tgt : m_pend);
                    m_dropping = 0;
                end
                if (src) m_pend = tgt;
            end else if (ack) begin
                if (src) m_pc = word_addr(tgt);
                else begin m_instr = rdata; m_valid = 1; m_waiting = 0; end
            end else if (src) begin
                m_pend = tgt; m_dropping = 1;
            end
        end else begin
            if (src) begin
                m_pc = word_addr(tgt); m_instr = 32'h0; m_valid = 0; m_waiting = 1;
            end else if (!stall) begin
                m_pc = m_pc + 32'd4; m_valid = 0; m_waiting = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        StallF = 0; PCSrcE = 0; PCTargetE = '0; imem_ack = 0; imem_rdata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (PCF !== RPC || PCPlus4F !== RPC + 32'd4) begin
            tests_failed++;
            $display("[TB] FAIL reset_pc: PCF=%h PCPlus4F=%h, want %h %h", PCF, PCPlus4F, RPC, RPC + 32'd4);
        end
        tests_run++;
        if (imem_req !== 1'b0 || ValidF !== 1'b0 || InstrF !== 32'h0 || FetchStall !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: req=%b valid=%b instr=%h stall=%b, want 0 0 0 1",
                     imem_req, ValidF, InstrF, FetchStall);
        end
    endtask

    task automatic test_stream();
        logic [31:0] w;
        for (int k = 1; k <= 6; k++) begin
            w = $urandom;
            applyStimulus(0, 0, 32'h0, 1, w);
            tests_run++;
            if (k % 2 == 1) begin
                if (imem_req !== 1'b1 || imem_addr !== RPC + 32'(4 * ((k - 1) / 2)) || ValidF !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL stream_req%0d: req=%b addr=%h valid=%b, want 1 %h 0",
                             k, imem_req, imem_addr, ValidF, RPC + 32'(4 * ((k - 1) / 2)));
                end
            end else begin
                if (imem_req !== 1'b0 || ValidF !== 1'b1 || InstrF !== w || PCF !== RPC + 32'(4 * ((k - 2) / 2))) begin
                    tests_failed++;
                    $display("[TB] FAIL stream_data%0d: req=%b valid=%b instr=%h pc=%h, want 0 1 %h %h",
                             k, imem_req, ValidF, InstrF, PCF, w, RPC + 32'(4 * ((k - 2) / 2)));
                end
            end
        end
    endtask

    logic [31:0] held_word;

    task automatic test_wait_ack();
        do_reset();
        applyStimulus(0, 0, 32'h0, 1, 32'h1111_1111);
        applyStimulus(0, 0, 32'h0, 1, 32'h2222_2222);
        applyStimulus(0, 0, 32'h0, 0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 32'h0, 0, 32'hDEAD_0000 + 32'(k));
            tests_run++;
            if (imem_addr !== 32'h104 || FetchStall !== 1'b1 || ValidF !== 1'b0 || imem_req !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL wait_ack%0d: addr=%h stall=%b valid=%b req=%b, want 104 1 0 1",
                         k, imem_addr, FetchStall, ValidF, imem_req);
            end
        end
        held_word = 32'hCAFE_0104;
        applyStimulus(0, 0, 32'h0, 1, held_word);
        tests_run++;
        if (ValidF !== 1'b1 || InstrF !== held_word || PCF !== 32'h104) begin
            tests_failed++;
            $display("[TB] FAIL wait_ack_data: valid=%b instr=%h pc=%h, want 1 %h 104", ValidF, InstrF, PCF, held_word);
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 0, 32'h0, 1, 32'hBAD0_0000 + 32'(k));
            tests_run++;
            if (InstrF !== held_word || PCF !== 32'h104 || ValidF !== 1'b1 || imem_req !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL stall_hold%0d: instr=%h pc=%h valid=%b req=%b, want %h 104 1 0",
                         k, InstrF, PCF, ValidF, imem_req, held_word);
            end
        end
        applyStimulus(0, 0, 32'h0, 0, 32'h0);
        tests_run++;
        if (PCF !== 32'h108 || imem_req !== 1'b1 || ValidF !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL stall_release: pc=%h req=%b valid=%b, want 108 1 0", PCF, imem_req, ValidF);
        end
    endtask

    task automatic test_redirect_fetch();
        applyStimulus(0, 1, 32'h200, 0, 32'h0);
        tests_run++;
        if (PCF !== 32'h108 || imem_addr !== 32'h108 || imem_req !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL redir_fetch_hold: pc=%h addr=%h req=%b, want 108 108 1", PCF, imem_addr, imem_req);
        end
        applyStimulus(0, 0, 32'h0, 0, 32'h0);
        applyStimulus(0, 0, 32'h0, 1, 32'hBAD_BAD00);
        tests_run++;
        if (imem_addr !== 32'h200 || ValidF !== 1'b0 || InstrF !== held_word || imem_req !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL redir_fetch_drop: addr=%h valid=%b instr=%h req=%b, want 200 0 %h 1",
                     imem_addr, ValidF, InstrF, imem_req, held_word);
        end
        applyStimulus(0, 0, 32'h0, 1, 32'h600D_0200);
        tests_run++;
        if (ValidF !== 1'b1 || InstrF !== 32'h600D_0200 || PCF !== 32'h200) begin
            tests_failed++;
            $display("[TB] FAIL redir_fetch_new: valid=%b instr=%h pc=%h, want 1 600d0200 200", ValidF, InstrF, PCF);
        end
    endtask

    task automatic test_redirect_have();
        applyStimulus(1, 1, 32'h203, 0, 32'h0);
        tests_run++;
        if (PCF !== 32'h200 || PCPlus4F !== 32'h204 || ValidF !== 1'b0 || InstrF !== 32'h0
            || imem_req !== 1'b1 || FetchStall !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL redir_have: pc=%h p4=%h valid=%b instr=%h req=%b stall=%b, want 200 204 0 0 1 1",
                     PCF, PCPlus4F, ValidF, InstrF, imem_req, FetchStall);
        end
    endtask

    task automatic test_wrap();
        applyStimulus(0, 1, 32'hFFFF_FFFE, 1, 32'h0);
        tests_run++;
        if (PCF !== 32'hFFFF_FFFC || PCPlus4F !== 32'h0 || ValidF !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL wrap_load: pc=%h p4=%h valid=%b, want fffffffc 0 0", PCF, PCPlus4F, ValidF);
        end
        applyStimulus(0, 0, 32'h0, 1, 32'h1234_5678);
        applyStimulus(0, 0, 32'h0, 0, 32'h0);
        tests_run++;
        if (PCF !== 32'h0 || PCPlus4F !== 32'h4 || imem_addr !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL wrap_adv: pc=%h p4=%h addr=%h, want 0 4 0", PCF, PCPlus4F, imem_addr);
        end
    endtask

    task automatic test_reset_mid();
        imem_ack = 0;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (imem_req !== 1'b0 || PCF !== RPC || ValidF !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_async: req=%b pc=%h valid=%b, want 0 %h 0", imem_req, PCF, ValidF, RPC);
        end
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 32'h0, 1, 32'hDEAD_BEEF);
        tests_run++;
        if (InstrF !== 32'h0 || ValidF !== 1'b0 || imem_addr !== RPC || imem_req !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_abandon: instr=%h valid=%b addr=%h req=%b, want 0 0 %h 1",
                     InstrF, ValidF, imem_addr, imem_req, RPC);
        end
    endtask

    task automatic test_random();
        logic s, r, a;
        logic [31:0] t, d;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            s = ($urandom_range(0, 9) < 3);
            r = ($urandom_range(0, 9) < 2);
            a = ($urandom_range(0, 9) < 6);
            t = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : 32'h0) | $urandom_range(0, 32'h3FF);
            d = $urandom;
            applyStimulus(s, r, t, a, d);
            tests_run++;
            if (PCF !== m_pc || PCPlus4F !== m_pc + 32'd4 || imem_addr !== word_addr(m_pc)
                || imem_req !== (m_started && m_waiting) || InstrF !== m_instr || ValidF !== m_valid
                || FetchStall !== !(m_started && !m_waiting)) begin
                tests_failed++;
                $display("[TB] FAIL random%0d: pc=%h p4=%h addr=%h req=%b instr=%h valid=%b stall=%b, want %h %h %h %b %h %b %b",
                         k, PCF, PCPlus4F, imem_addr, imem_req, InstrF, ValidF, FetchStall,
                         m_pc, m_pc + 32'd4, word_addr(m_pc), m_started && m_waiting, m_instr, m_valid,
                         !(m_started && !m_waiting));
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_wait_ack();
        test_stall();
        test_redirect_fetch();
        test_redirect_have();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
